// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmit FIFO: byte handshake plus occupancy/status flags.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          wr_en;
  logic [7:0]                    wr_data;
  logic                          full;
  logic                          empty;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport master (output wr_en, wr_data, input full, empty, count, overflow);
  modport slave  (input wr_en, wr_data, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO; back-to-back frames when data is queued.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more data is queued
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          tx,
  output logic          is_transmitting
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          full, empty, push, pop;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d, baud_done;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Room is judged on the pre-edge full flag, so a same-cycle pop never frees space for a write.
  assign push  = bus.wr_en && !full;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.wr_en && full) overflow_q <= 1'b1;
    end
  end

  assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is heading
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

  assign is_transmitting = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-plus-frame-timeline reference model.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic is_transmitting;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .tx              (tx),
    .is_transmitting (is_transmitting)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: queued bytes, plus the byte on the line and how far into its frame we are.
  byte unsigned q[$];
  bit           m_busy = 1'b0;
  int           m_t    = 0;
  byte unsigned m_cur  = 8'h00;
  bit           m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic model_tx();
    int pos;
    if (!m_busy) return 1'b1;
    pos = m_t / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
    return 1'b1;
  endfunction

  task automatic step(input bit rst, input bit we, input byte unsigned d);
    bit was_full;
    bit can_pop;
    reset       = rst;
    bus.wr_en   = we;
    bus.wr_data = d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_ovf  = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      can_pop  = (q.size() != 0);
      if (!m_busy || m_t == FRAME - 1) begin
        if (can_pop) begin
          m_cur  = q.pop_front();
          m_busy = 1'b1;
          m_t    = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_t++;
      end
      if (we) begin
        if (was_full) m_ovf = 1'b1;
        else q.push_back(d);
      end
    end
    #1;
    chk("tx", tx, model_tx());
    chk("is_transmitting", is_transmitting, m_busy);
    chk("count", bus.count, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == DEPTH);
    chk("overflow", bus.overflow, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  int max_cnt;
  int rate;

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    chk("reset_tx", tx, 1'b1);
    chk("reset_empty", bus.empty, 1'b1);

    // single byte 0x48: start at N+1, done at N+41
    step(1'b0, 1'b1, 8'h48);
    for (int k = 1; k <= 45; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (k == 1)  chk("single_start_bit", tx, 1'b0);
      if (k == 2)  chk("single_empty", bus.empty, 1'b1);
      if (k == 40) chk("single_busy_end", is_transmitting, 1'b1);
      if (k == 41) chk("single_busy_fall", is_transmitting, 1'b0);
    end

    // five writes while idle, then a sixth into a full FIFO
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h41 + i));
    chk("burst_count", bus.count, 4);
    chk("burst_full", bus.full, 1'b1);
    chk("burst_no_ovf", bus.overflow, 1'b0);
    step(1'b0, 1'b1, 8'hEE);
    chk("drop_count", bus.count, 4);
    chk("drop_ovf", bus.overflow, 1'b1);
    idle(210);
    chk("ovf_sticky", bus.overflow, 1'b1);

    // reset 15 cycles into a frame, then an all-zero byte
    step(1'b0, 1'b1, 8'hA5);
    idle(15);
    step(1'b1, 1'b0, 8'h00);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", is_transmitting, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    idle(45);

    // pointer wrap: 12 writes spaced a frame apart
    max_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      for (int j = 0; j < 39; j++) begin
        step(1'b0, 1'b0, 8'h00);
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      end
    end
    chk("wrap_max_count_le1", max_cnt <= 1, 1'b1);
    idle(45);

    // random traffic with varying write density and occasional reset
    for (int blk = 0; blk < 6; blk++) begin
      rate = $urandom_range(1, 60);
      for (int i = 0; i < 250; i++) begin
        step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < rate),
             8'($urandom_range(0, 255)));
      end
    end
    idle(FRAME * (DEPTH + 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
